// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single write port of the 8x16 register file
// between NREQ writeback sources; all register-file-facing outputs are registered.
module regfile_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_addr,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 rf_write_n,
    output logic [2:0]           rf_addr,
    output logic [15:0]          rf_data,
    output logic [7:0]           pending,
    output logic [15:0]          grant_count
);

    logic [NREQ-1:0]  gnt_q,  gnt_d;
    logic             wr_n_q, wr_n_d;
    logic [2:0]       addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic [PTR_W-1:0] ptr_q,  ptr_d;
    logic [15:0]      cnt_q,  cnt_d;

    logic [NREQ-1:0]  eligible;
    logic [2:0]       addr_arr [NREQ];
    logic [15:0]      data_arr [NREQ];
    logic [7:0]       dec_arr  [NREQ];
    logic             found;
    logic [PTR_W-1:0] win;

    // A requester whose grant is currently high sits out one arbitration round.
    assign eligible = req & ~gnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign addr_arr[gi] = req_addr[3*gi +: 3];
            assign data_arr[gi] = req_data[16*gi +: 16];
            assign dec_arr[gi]  = eligible[gi] ? (8'b1 << addr_arr[gi]) : 8'b0;
        end
    endgenerate

    always_comb begin
        pending = 8'b0;
        for (int i = 0; i < NREQ; i++) begin
            pending = pending | dec_arr[i];
        end
    end

    // Rotating priority search starting at ptr_q, wrapping at NREQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_d  = '0;
        wr_n_d = 1'b1;
        addr_d = addr_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (!hold && found) begin
            gnt_d  = NREQ'(1) << win;
            wr_n_d = 1'b0;
            addr_d = addr_arr[win];
            data_d = data_arr[win];
            ptr_d  = (int'(win) == NREQ - 1) ? '0 : win + PTR_W'(1);
            cnt_d  = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q  <= '0;
            wr_n_q <= 1'b1;
            addr_q <= 3'd0;
            data_q <= 16'd0;
            ptr_q  <= '0;
            cnt_q  <= 16'd0;
        end else begin
            gnt_q  <= gnt_d;
            wr_n_q <= wr_n_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign rf_write_n  = wr_n_q;
    assign rf_addr     = addr_q;
    assign rf_data     = data_q;
    assign grant_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_regfile_write_arbiter;

    localparam int NREQ  = 4;
    localparam int PTR_W = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [3*NREQ-1:0]    req_addr;
    logic [16*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 rf_write_n;
    logic [2:0]           rf_addr;
    logic [15:0]          rf_data;
    logic [7:0]           pending;
    logic [15:0]          grant_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index of the requester holding the grant (-1 = none)
    int          m_gnt;
    logic        m_wn;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    int          m_ptr;
    int          m_cnt;

    regfile_write_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
        .rf_write_n(rf_write_n), .rf_addr(rf_addr), .rf_data(rf_data),
        .pending(pending), .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] m_gnt_vec();
        return (m_gnt < 0) ? '0 : NREQ'(1) << m_gnt;
    endfunction

    function automatic logic [7:0] m_pending();
        logic [7:0] p = 8'b0;
        for (int i = 0; i < NREQ; i++)
            if (req[i] && i != m_gnt) p[req_addr[3*i +: 3]] = 1'b1;
        return p;
    endfunction

    // Advance one clock edge and move the model forward using the inputs seen at that edge.
    task automatic tick();
        int w;
        @(posedge clk);
        if (reset) begin
            m_gnt = -1; m_wn = 1'b1; m_addr = 3'd0; m_data = 16'd0; m_ptr = 0; m_cnt = 0;
        end else if (hold) begin
            m_gnt = -1; m_wn = 1'b1;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx = (m_ptr + k) % NREQ;
                if (w < 0 && req[idx] && idx != m_gnt) w = idx;
            end
            if (w >= 0) begin
                m_gnt  = w;
                m_wn   = 1'b0;
                m_addr = req_addr[3*w +: 3];
                m_data = req_data[16*w +: 16];
                m_ptr  = (w + 1) % NREQ;
                m_cnt  = (m_cnt + 1) % 65536;
            end else begin
                m_gnt = -1;
                m_wn  = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; req = 4'b1111;
        req_addr = 12'hFFF; req_data = {4{16'hA5A5}};
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin reset = 1'b0; req = '0; end
            n_checks++;
            if (gnt !== 4'b0 || rf_write_n !== 1'b1 || rf_addr !== 3'd0 ||
                rf_data !== 16'd0 || grant_count !== 16'd0) begin
                n_errors++;
                $display("FAIL reset_idle c=%0d gnt=%b wn=%b addr=%0d data=%h cnt=%0d expected 0/1/0/0/0",
                         c, gnt, rf_write_n, rf_addr, rf_data, grant_count);
            end
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0 || rf_write_n !== 1'b1 || grant_count !== 16'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset gnt=%b wn=%b cnt=%0d expected 0/1/0", gnt, rf_write_n, grant_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        req_addr[8:6]   = 3'd5;
        req_data[47:32] = 16'hBEEF;
        req = 4'b0100;
        #1;
        n_checks++;
        if (pending !== 8'b0010_0000) begin
            n_errors++;
            $display("FAIL single_pending got=%b expected=00100000", pending);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0100 || rf_write_n !== 1'b0 || rf_addr !== 3'd5 || rf_data !== 16'hBEEF ||
            grant_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_grant gnt=%b wn=%b addr=%0d data=%h cnt=%0d expected 0100/0/5/beef/1",
                     gnt, rf_write_n, rf_addr, rf_data, grant_count);
        end
        n_checks++;
        if (pending !== 8'b0) begin
            n_errors++;
            $display("FAIL single_pending_granted got=%b expected=0", pending);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0 || rf_write_n !== 1'b1 || rf_addr !== 3'd5 || rf_data !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL single_gap gnt=%b wn=%b addr=%0d data=%h expected 0000/1/5/beef",
                     gnt, rf_write_n, rf_addr, rf_data);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0100 || rf_write_n !== 1'b0 || grant_count !== 16'd2) begin
            n_errors++;
            $display("FAIL single_regrant gnt=%b wn=%b cnt=%0d expected 0100/0/2", gnt, rf_write_n, grant_count);
        end
        req = '0;
        tick();
        $display("test_single_write done");
    endtask

    task automatic test_round_robin();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[3*i +: 3]  = 3'(i);
            req_data[16*i +: 16] = 16'h1000 + 16'(i);
        end
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (gnt !== (NREQ'(1) << (c % NREQ)) || rf_write_n !== 1'b0 ||
                rf_addr !== 3'(c % NREQ) || rf_data !== 16'h1000 + 16'(c % NREQ) ||
                grant_count !== 16'(c + 1)) begin
                n_errors++;
                $display("FAIL round_robin c=%0d gnt=%b wn=%b addr=%0d data=%h cnt=%0d expected gnt=%b cnt=%0d",
                         c, gnt, rf_write_n, rf_addr, rf_data, grant_count, NREQ'(1) << (c % NREQ), c + 1);
            end
        end
        req = '0;
        tick();
        $display("test_round_robin done");
    endtask

    task automatic test_hold();
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b0011;
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_errors++;
            $display("FAIL hold_pre gnt=%b expected=0001", gnt);
        end
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (gnt !== 4'b0 || rf_write_n !== 1'b1 || grant_count !== 16'd1) begin
                n_errors++;
                $display("FAIL hold_frozen c=%0d gnt=%b wn=%b cnt=%0d expected 0000/1/1",
                         c, gnt, rf_write_n, grant_count);
            end
        end
        hold = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || grant_count !== 16'd2) begin
            n_errors++;
            $display("FAIL hold_resume gnt=%b cnt=%0d expected 0010/2", gnt, grant_count);
        end
        req = '0;
        tick();
        $display("test_hold done");
    endtask

    task automatic test_same_dest();
        reset = 1'b1; tick(); reset = 1'b0;
        req_addr[2:0] = 3'd3; req_data[15:0]  = 16'h1111;
        req_addr[5:3] = 3'd3; req_data[31:16] = 16'h2222;
        req = 4'b0011;
        #1;
        n_checks++;
        if (pending !== 8'b0000_1000) begin
            n_errors++;
            $display("FAIL same_pending0 got=%b expected=00001000", pending);
        end
        tick();
        req = 4'b0010;
        #1;
        n_checks++;
        if (gnt !== 4'b0001 || rf_addr !== 3'd3 || rf_data !== 16'h1111 || pending !== 8'b0000_1000) begin
            n_errors++;
            $display("FAIL same_first gnt=%b addr=%0d data=%h pend=%b expected 0001/3/1111/00001000",
                     gnt, rf_addr, rf_data, pending);
        end
        tick();
        req = '0;
        #1;
        n_checks++;
        if (gnt !== 4'b0010 || rf_addr !== 3'd3 || rf_data !== 16'h2222 || pending !== 8'b0) begin
            n_errors++;
            $display("FAIL same_second gnt=%b addr=%0d data=%h pend=%b expected 0010/3/2222/0",
                     gnt, rf_addr, rf_data, pending);
        end
        tick();
        $display("test_same_dest done");
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b1010;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (gnt !== 4'b0 || rf_write_n !== 1'b1 || grant_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid gnt=%b wn=%b cnt=%0d expected 0000/1/0", gnt, rf_write_n, grant_count);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0010 || rf_write_n !== 1'b0 || grant_count !== 16'd1) begin
            n_errors++;
            $display("FAIL reset_mid_first gnt=%b wn=%b cnt=%0d expected 0010/0/1", gnt, rf_write_n, grant_count);
        end
        req = '0;
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int errs_before = n_errors;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                // Requester contract: only change a request once idle or just granted.
                if (!req[i] || gnt[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    req_addr[3*i +: 3]   = 3'($urandom_range(0, 7));
                    req_data[16*i +: 16] = 16'($urandom);
                end
            end
            hold  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            #1;
            n_checks++;
            if (pending !== m_pending()) begin
                n_errors++;
                $display("FAIL rand_pending c=%0d got=%b expected=%b", c, pending, m_pending());
            end
            tick();
            n_checks++;
            if (gnt !== m_gnt_vec() || rf_write_n !== m_wn || rf_addr !== m_addr ||
                rf_data !== m_data || grant_count !== 16'(m_cnt)) begin
                n_errors++;
                $display("FAIL rand_out c=%0d gnt=%b/%b wn=%b/%b addr=%0d/%0d data=%h/%h cnt=%0d/%0d (got/expected)",
                         c, gnt, m_gnt_vec(), rf_write_n, m_wn, rf_addr, m_addr,
                         rf_data, m_data, grant_count, m_cnt);
            end
        end
        reset = 1'b0; hold = 1'b0; req = '0;
        tick();
        $display("test_random done, %0d new errors", n_errors - errs_before);
    endtask

    initial begin
        m_gnt = -1; m_wn = 1'b1; m_addr = 3'd0; m_data = 16'd0; m_ptr = 0; m_cnt = 0;
        reset = 1'b1; hold = 1'b0; req = '0; req_addr = '0; req_data = '0;
        #2;
        test_reset();
        test_single_write();
        test_round_robin();
        test_hold();
        test_same_dest();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
